// File: rtl/aes_port_pkg.sv
// ---------------------------------------------------------------------------
// aes_port_pkg
// Shared definitions for the AES chip's block<->lane port logic (transmit
// and receive sides).
//   port_state_e : two-state port controller encoding (IDLE, SEND)
//   beats_of()   : number of lane beats that make up one block
//   cnt_w_of()   : width of a beat index able to address every beat
// ---------------------------------------------------------------------------
package aes_port_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } port_state_e;

  function automatic int beats_of(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Never narrower than one bit so a degenerate configuration still elaborates
  // far enough to hit the parameter checks in the top level.
  function automatic int cnt_w_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/aes_tx_lane_sel.sv
// ---------------------------------------------------------------------------
// aes_tx_lane_sel
// Combinational lane multiplexer: picks beat idx out of a DATA_W-bit block.
//   blk  in  DATA_W  block being transmitted
//   idx  in  CNT_W   beat index (0 = first beat on the wire)
//   tx   out LANE_W  selected lane
// MSB_FIRST=1 maps beat 0 to the most-significant lane, MSB_FIRST=0 to the
// least-significant lane.
// ---------------------------------------------------------------------------
module aes_tx_lane_sel
  import aes_port_pkg::*;
#(
  parameter int  DATA_W    = 128,
  parameter int  LANE_W    = 8,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int BEATS     = beats_of(DATA_W, LANE_W),
  localparam int CNT_W     = cnt_w_of(BEATS)
) (
  input  logic [DATA_W-1:0] blk,
  input  logic [CNT_W-1:0]  idx,
  output logic [LANE_W-1:0] tx
);

  // Table covers the full index range; slots past the last beat are zero so
  // the mux never reads outside the array for non-power-of-two beat counts.
  localparam int SLOTS = 1 << CNT_W;

  logic [LANE_W-1:0] lane_arr [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_lane
      if (gi < BEATS) begin : g_used
        if (MSB_FIRST) begin : g_msb
          assign lane_arr[gi] = blk[DATA_W-1-gi*LANE_W -: LANE_W];
        end else begin : g_lsb
          assign lane_arr[gi] = blk[gi*LANE_W +: LANE_W];
        end
      end else begin : g_pad
        assign lane_arr[gi] = '0;
      end
    end
  endgenerate

  assign tx = lane_arr[idx];

endmodule

// File: rtl/aes_block_tx.sv
// ---------------------------------------------------------------------------
// aes_block_tx
// Block-to-lane serialiser for the AES output port. Pops DATA_W-bit blocks
// from a first-word-fall-through FIFO and sends each as DATA_W/LANE_W beats.
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   en        in   clock enable (require still self-clears while low)
//   flush     in   synchronous abort of the current block, ignores en
//   data      in   FIFO head word, valid when empty=0
//   empty     in   FIFO empty
//   require   out  one-cycle FIFO pop pulse (cycle after a load)
//   tx        out  current beat (combinational from block register + idx)
//   tx_valid  out  tx holds a beat
//   tx_ready  in   receiver accepts the beat
//   tx_first  out  beat 0 of a block
//   tx_last   out  final beat of a block
//   shakehand out  toggles on every accepted beat
//   busy      out  controller is sending a block
// ---------------------------------------------------------------------------
module aes_block_tx
  import aes_port_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int LANE_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [DATA_W-1:0] data,
  input  logic              empty,
  output logic              require,
  output logic [LANE_W-1:0] tx,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_first,
  output logic              tx_last,
  output logic              shakehand,
  output logic              busy
);

  localparam int               BEATS    = beats_of(DATA_W, LANE_W);
  localparam int               CNT_W    = cnt_w_of(BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  generate
    if (DATA_W % LANE_W != 0) begin : g_bad_div
      $error("aes_block_tx: DATA_W must be a multiple of LANE_W");
    end
    // A single-beat block would allow a reload before the previous pop has
    // reached the FIFO's empty flag.
    if (BEATS < 2) begin : g_bad_beats
      $error("aes_block_tx: DATA_W/LANE_W must be at least 2");
    end
  endgenerate

  port_state_e       state_reg, state_next;
  logic [CNT_W-1:0]  idx_reg, idx_next;
  logic [DATA_W-1:0] blk_reg, blk_next;
  logic              require_reg, require_next;
  logic              shake_reg, shake_next;
  logic              is_last;

  assign is_last = (idx_reg == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      blk_reg     <= '0;
      require_reg <= 1'b0;
      shake_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      blk_reg     <= blk_next;
      require_reg <= require_next;
      shake_reg   <= shake_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    blk_next     = blk_reg;
    shake_next   = shake_reg;
    // require is a pulse: it is only ever set for the cycle following a
    // load, so a frozen (en=0) cycle cannot stretch it.
    require_next = 1'b0;

    if (flush) begin
      // Abort wins over any load or accept in the same cycle.
      state_next = IDLE;
      idx_next   = '0;
    end else if (en) begin
      unique case (state_reg)
        IDLE: begin
          if (!empty) begin
            blk_next     = data;
            idx_next     = '0;
            require_next = 1'b1;
            state_next   = SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            shake_next = ~shake_reg;
            if (!is_last) begin
              idx_next = idx_reg + CNT_W'(1);
            end else if (!empty) begin
              // Back-to-back reload keeps the lane busy with no bubble.
              blk_next     = data;
              idx_next     = '0;
              require_next = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  aes_tx_lane_sel #(
    .DATA_W    (DATA_W),
    .LANE_W    (LANE_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane_sel (
    .blk (blk_reg),
    .idx (idx_reg),
    .tx  (tx)
  );

  assign tx_valid  = (state_reg == SEND);
  assign busy      = (state_reg == SEND);
  assign tx_first  = tx_valid && (idx_reg == '0);
  assign tx_last   = tx_valid && is_last;
  assign require   = require_reg;
  assign shakehand = shake_reg;

endmodule

// File: tb/tb_aes_block_tx.sv
// ---------------------------------------------------------------------------
// tb_aes_block_tx
// Drives the default 128->8 MSB-first transmitter from a queue-based FIFO
// model and scores every cycle against an expected-beat queue built from
// each popped block. A second 128->32 LSB-first instance checks lane order.
// ---------------------------------------------------------------------------
module tb_aes_block_tx;

  localparam logic [127:0] T1_DATA = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         flush;
  logic [127:0] data;
  logic         empty;
  logic         require;
  logic [7:0]   tx;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_first;
  logic         tx_last;
  logic         shakehand;
  logic         busy;

  logic [127:0] data2;
  logic         empty2;
  logic         require2;
  logic [31:0]  tx2;
  logic         tx_valid2;
  logic         tx_first2;
  logic         tx_last2;
  logic         shake2;
  logic         busy2;

  always #5 clk = ~clk;

  aes_block_tx dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .data      (data),
    .empty     (empty),
    .require   (require),
    .tx        (tx),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_first  (tx_first),
    .tx_last   (tx_last),
    .shakehand (shakehand),
    .busy      (busy)
  );

  aes_block_tx #(
    .DATA_W    (128),
    .LANE_W    (32),
    .MSB_FIRST (1'b0)
  ) dut32 (
    .clk       (clk),
    .rst       (rst),
    .en        (1'b1),
    .flush     (1'b0),
    .data      (data2),
    .empty     (empty2),
    .require   (require2),
    .tx        (tx2),
    .tx_valid  (tx_valid2),
    .tx_ready  (1'b1),
    .tx_first  (tx_first2),
    .tx_last   (tx_last2),
    .shakehand (shake2),
    .busy      (busy2)
  );

  typedef struct packed {
    logic [7:0] lane;
    logic       first;
    logic       last;
  } beat_t;

  logic [127:0] fifo_q [$];
  beat_t        exp_q  [$];
  logic         exp_req   = 1'b0;
  logic         exp_shake = 1'b0;
  int           errors = 0;
  int           checks = 0;
  int           pushes = 0;
  int           pops   = 0;
  logic [31:0]  w2 [4];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, want);
    end
  endtask

  task automatic refresh();
    empty = (fifo_q.size() == 0);
    data  = empty ? '0 : fifo_q[0];
  endtask

  task automatic push_blk(input logic [127:0] b);
    fifo_q.push_back(b);
    pushes++;
    refresh();
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_tx"},        tx,        0);
    chk({pfx, "_tx_valid"},  tx_valid,  0);
    chk({pfx, "_tx_first"},  tx_first,  0);
    chk({pfx, "_tx_last"},   tx_last,   0);
    chk({pfx, "_require"},   require,   0);
    chk({pfx, "_shakehand"}, shakehand, 0);
    chk({pfx, "_busy"},      busy,      0);
  endtask

  // One clock cycle: score outputs mid-cycle, advance the reference, then let
  // the FIFO model react to the pop the DUT requested during this cycle.
  task automatic step();
    logic         dut_req;
    logic         idle;
    logic         acc;
    logic         last_beat;
    logic [127:0] blk;
    @(negedge clk);
    dut_req = require;
    chk("require", require, exp_req);
    if (exp_req && fifo_q.size() != 0) begin
      blk = fifo_q[0];
      $display("load block %h", blk);
      for (int k = 0; k < 16; k++) begin
        exp_q.push_back('{lane: 8'(blk >> (8 * (15 - k))), first: (k == 0), last: (k == 15)});
      end
    end
    chk("tx_valid", tx_valid, exp_q.size() != 0);
    chk("busy", busy, exp_q.size() != 0);
    chk("shakehand", shakehand, exp_shake);
    if (exp_q.size() != 0) begin
      chk("tx", tx, exp_q[0].lane);
      chk("tx_first", tx_first, exp_q[0].first);
      chk("tx_last", tx_last, exp_q[0].last);
    end
    idle    = (exp_q.size() == 0);
    acc     = en && !idle && tx_ready && !flush;
    exp_req = 1'b0;
    if (flush) begin
      exp_q.delete();
    end else if (acc) begin
      last_beat = exp_q[0].last;
      void'(exp_q.pop_front());
      exp_shake = ~exp_shake;
      if (last_beat && !empty) exp_req = 1'b1;
    end else if (idle && en && !empty) begin
      exp_req = 1'b1;
    end
    @(posedge clk);
    #1;
    if (dut_req && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    refresh();
  endtask

  initial begin
    int got2;
    logic r2;
    rst      = 1'b1;
    en       = 1'b0;
    flush    = 1'b0;
    tx_ready = 1'b0;
    empty2   = 1'b1;
    data2    = T1_DATA;
    w2[0] = 32'hCCDDEEFF;
    w2[1] = 32'h8899AABB;
    w2[2] = 32'h44556677;
    w2[3] = 32'h00112233;
    refresh();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst      = 1'b0;
    en       = 1'b1;
    tx_ready = 1'b1;

    // 128->32, LSB lane first
    empty2 = 1'b0;
    got2   = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (tx_valid2 && got2 < 4) begin
        chk($sformatf("lane32_beat%0d", got2), tx2, w2[got2]);
        chk($sformatf("lane32_first%0d", got2), tx_first2, got2 == 0);
        chk($sformatf("lane32_last%0d", got2), tx_last2, got2 == 3);
        chk($sformatf("lane32_busy%0d", got2), busy2, 1);
        got2++;
      end
      r2 = require2;
      @(posedge clk);
      #1;
      if (r2) empty2 = 1'b1;
    end
    chk("lane32_count", got2, 4);
    chk("lane32_shake", shake2, 0);

    // single block with the reference pattern
    push_blk(T1_DATA);
    repeat (20) step();

    // two queued blocks, back to back
    push_blk(rnd_blk());
    push_blk(rnd_blk());
    repeat (36) step();

    // backpressure for 5 cycles at beat 3
    push_blk(rnd_blk());
    step();
    repeat (3) step();
    tx_ready = 1'b0;
    repeat (5) step();
    tx_ready = 1'b1;
    repeat (16) step();

    // en low for 3 cycles starting in the require cycle
    push_blk(rnd_blk());
    step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (18) step();

    // flush at beat 7 with another block waiting
    push_blk(rnd_blk());
    push_blk(rnd_blk());
    step();
    repeat (7) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (20) step();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 3) == 0) push_blk(rnd_blk());
      en       = ($urandom_range(0, 9) != 0);
      tx_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 49) == 0);
      step();
    end
    en       = 1'b1;
    tx_ready = 1'b1;
    flush    = 1'b0;
    for (int c = 0; c < 100 && (fifo_q.size() != 0 || exp_q.size() != 0); c++) step();
    chk("drain_fifo", fifo_q.size(), 0);
    chk("drain_beats", exp_q.size(), 0);

    // asynchronous reset mid-block
    push_blk(rnd_blk());
    step();
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    exp_shake = 1'b0;
    exp_req   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) step();

    chk("pops", pops, pushes);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
